// File: rtl/video_pattern_gen_pkg.sv
// rtl/video_pattern_gen_pkg.sv - timing defaults, pattern/FSM encodings and LFSR/box-motion helpers
package video_pattern_gen_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_BOX_W    = 64;
    localparam int DEF_BOX_H    = 48;
    localparam int DEF_BOX_STEP = 4;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        PAT_ZERO    = 2'd0,
        PAT_BOX     = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_NOISE   = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        if (cur == 16'h0000) begin
            return LFSR_SEED;
        end
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Returns {direction_is_negative, position} after one frame of motion with bounce/clamp.
    function automatic logic [CNT_W:0] bounce(
        input logic [CNT_W-1:0] pos,
        input logic             neg,
        input logic [CNT_W-1:0] step,
        input logic [CNT_W-1:0] lim
    );
        if (!neg) begin
            if (({1'b0, pos} + {1'b0, step}) > {1'b0, lim}) begin
                return {1'b1, lim};
            end
            return {1'b0, pos + step};
        end
        if (pos < step) begin
            return {1'b0, {CNT_W{1'b0}}};
        end
        return {1'b1, pos - step};
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// rtl/video_timing_cnt.sv - h/v raster counters with sync, active and frame-end decode
module video_timing_cnt
    import video_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign last   = h_last && v_last;

    // Counters sit at the origin whenever the generator is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + ONE;
        end else begin
            h_cnt <= h_cnt + ONE;
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - run/drain FSM and binary test-pattern generator over the raster counters
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int BOX_W    = DEF_BOX_W,
    parameter int BOX_H    = DEF_BOX_H,
    parameter int BOX_STEP = DEF_BOX_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       pattern_sel,
    output logic             o_vs,
    output logic             o_hs,
    output logic             o_clken,
    output logic             o_imgbit,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             frame_done
);

    localparam int EXT_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] X_LIM  = CNT_W'(H_ACTIVE - BOX_W);
    localparam logic [CNT_W-1:0] Y_LIM  = CNT_W'(V_ACTIVE - BOX_H);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(BOX_STEP);
    localparam logic [EXT_W-1:0] BOX_WE = EXT_W'(BOX_W);
    localparam logic [EXT_W-1:0] BOX_HE = EXT_W'(BOX_H);

    state_e           state;
    state_e           state_nxt;
    logic             run;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             last;

    pattern_e         shadow_sel;
    pattern_e         sel_eff;
    logic             frame_start;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] box_x;
    logic [CNT_W-1:0] box_y;
    logic             box_x_neg;
    logic             box_y_neg;
    logic             in_box_x;
    logic             in_box_y;
    logic             in_box;
    logic             pix_bit;

    assign run = (state != ST_IDLE);

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hsync  (hsync),
        .vsync  (vsync),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping en on the final clock of a frame skips DRAIN: the frame is already complete.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_nxt = last ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last) state_nxt = en ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The first pixel of a frame must already use the newly sampled selection.
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    assign sel_eff     = frame_start ? pattern_e'(pattern_sel) : shadow_sel;

    assign in_box_x = ({1'b0, h_cnt} >= {1'b0, box_x}) && ({1'b0, h_cnt} < ({1'b0, box_x} + BOX_WE));
    assign in_box_y = ({1'b0, v_cnt} >= {1'b0, box_y}) && ({1'b0, v_cnt} < ({1'b0, box_y} + BOX_HE));
    assign in_box   = in_box_x && in_box_y;

    always_comb begin
        pix_bit = 1'b0;
        case (sel_eff)
            PAT_ZERO:    pix_bit = 1'b0;
            PAT_BOX:     pix_bit = in_box;
            PAT_CHECKER: pix_bit = h_cnt[3] ^ v_cnt[3];
            PAT_NOISE:   pix_bit = in_box ^ (lfsr[7:0] == 8'h00);
            default:     pix_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vs       <= 1'b0;
            o_hs       <= 1'b0;
            o_clken    <= 1'b0;
            o_imgbit   <= 1'b0;
            o_x        <= '0;
            o_y        <= '0;
            frame_done <= 1'b0;
        end else if (run) begin
            o_vs       <= vsync;
            o_hs       <= hsync;
            o_clken    <= active;
            o_imgbit   <= active && pix_bit;
            o_x        <= active ? h_cnt : '0;
            o_y        <= active ? v_cnt : '0;
            frame_done <= last;
        end else begin
            o_vs       <= 1'b0;
            o_hs       <= 1'b0;
            o_clken    <= 1'b0;
            o_imgbit   <= 1'b0;
            o_x        <= '0;
            o_y        <= '0;
            frame_done <= 1'b0;
        end
    end

    // Box moves in the blanking clock that closes each frame, so a frame never sees a split box.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_sel <= PAT_ZERO;
            lfsr       <= LFSR_SEED;
            box_x      <= '0;
            box_y      <= '0;
            box_x_neg  <= 1'b0;
            box_y_neg  <= 1'b0;
        end else begin
            if (frame_start) begin
                shadow_sel <= pattern_e'(pattern_sel);
            end
            if (run && active) begin
                lfsr <= lfsr_next(lfsr);
            end
            if (run && last) begin
                {box_x_neg, box_x} <= bounce(box_x, box_x_neg, STEP_C, X_LIM);
                {box_y_neg, box_y} <= bounce(box_y, box_y_neg, STEP_C, Y_LIM);
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed and randomized checks of video_pattern_gen against a pixel-index model
module tb_video_pattern_gen;

    localparam int HA = 32, HF = 2, HS = 3, HB = 3;
    localparam int VA = 24, VF = 1, VS = 2, VB = 1;
    localparam int BW = 8, BH = 6, BS = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic        o_vs, o_hs, o_clken, o_imgbit, frame_done;
    logic [10:0] o_x, o_y;

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .BOX_W (BW), .BOX_H (BH), .BOX_STEP (BS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .o_vs        (o_vs),
        .o_hs        (o_hs),
        .o_clken     (o_clken),
        .o_imgbit    (o_imgbit),
        .o_x         (o_x),
        .o_y         (o_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is a linear pixel index; generation continues while en is seen at frame end.
    int          m_active, m_pos, m_bx, m_by, m_vx, m_vy, m_sel;
    logic [15:0] m_lfsr;
    logic [4:0]  e_flags;
    int          e_x, e_y;
    bit          e_box;

    int clken_cnt, hs_cnt, fd_cnt, max_x, max_y, flips, nonzero, first_xy;
    bit pix_map [VA][HA];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            if (errors <= 10) $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0;
        m_bx = 0; m_by = 0; m_vx = BS; m_vy = BS;
        m_sel = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic move(inout int p, inout int vel, input int lim);
        int n;
        n = p + vel;
        if (n > lim) begin p = lim; vel = -vel; end
        else if (n < 0) begin p = 0; vel = -vel; end
        else p = n;
    endtask

    task automatic model_edge();
        int h, v;
        bit act, hs, vs, pix, last;
        e_flags = '0; e_x = 0; e_y = 0; e_box = 0;
        if (rst) begin model_reset(); return; end
        if (m_active == 0) begin
            if (en) begin m_active = 1; m_pos = 0; end
            return;
        end
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) m_sel = int'(pattern_sel);
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        pix = 0;
        if (act) begin
            e_box = (h >= m_bx) && (h < m_bx + BW) && (v >= m_by) && (v < m_by + BH);
            case (m_sel)
                1: pix = e_box;
                2: pix = (((h >> 3) ^ (v >> 3)) & 1) != 0;
                3: pix = e_box ^ (m_lfsr[7:0] == 8'h00);
                default: pix = 0;
            endcase
            if (m_lfsr == 16'h0) m_lfsr = 16'hACE1;
            else m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            e_x = h; e_y = v;
        end
        last = (m_pos == FT - 1);
        e_flags = {vs, hs, act, pix, last};
        if (last) begin
            move(m_bx, m_vx, HA - BW);
            move(m_by, m_vy, VA - BH);
            if (!en) m_active = 0;
        end
        m_pos = (m_pos + 1) % FT;
    endtask

    task automatic clear_stats();
        clken_cnt = 0; hs_cnt = 0; fd_cnt = 0; max_x = -1; max_y = -1;
        flips = 0; nonzero = 0; first_xy = -1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("flags", {o_vs, o_hs, o_clken, o_imgbit, frame_done}, e_flags);
        if (e_flags[2]) chk("xy", {o_x, o_y}, {e_x[10:0], e_y[10:0]});
        if (o_hs) hs_cnt++;
        if (frame_done) fd_cnt++;
        if ({o_vs, o_hs, o_clken, o_imgbit, frame_done, o_x, o_y} != '0) nonzero++;
        if (o_clken) begin
            clken_cnt++;
            if (first_xy < 0) first_xy = int'(o_x) * 4096 + int'(o_y);
            if (o_imgbit) begin
                if (int'(o_x) > max_x) max_x = int'(o_x);
                if (int'(o_y) > max_y) max_y = int'(o_y);
            end
            if (o_imgbit !== e_box) flips++;
            if (o_x < HA && o_y < VA) pix_map[o_y][o_x] = o_imgbit;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pattern_sel = 2'd0;
        model_reset();
        clear_stats();
        run(3);
        chk("reset_outputs", {o_vs, o_hs, o_clken, o_imgbit, frame_done, o_x, o_y}, 0);
        rst = 1'b0;
        run(5);
        chk("idle_outputs", nonzero, 0);

        // Moving box, frame-aligned from the IDLE->RUN clock.
        pattern_sel = 2'd1; en = 1'b1;
        step();
        clear_stats();
        run(FT);
        chk("clken_per_frame", clken_cnt, HA * VA);
        chk("hs_per_frame", hs_cnt, HS * VT);
        chk("fd_per_frame", fd_cnt, 1);
        clear_stats();
        run(14 * FT);
        chk("box_right_edge", max_x, HA - 1);
        chk("box_bottom_edge", max_y, VA - 1);
        chk("fd_14_frames", fd_cnt, 14);

        // Mid-frame selection changes only land on the following frame.
        run(500); pattern_sel = 2'd2; run(FT - 500);
        run(FT);
        chk("checker_8_0", pix_map[0][8], 1);
        chk("checker_0_0", pix_map[0][0], 0);
        chk("checker_8_8", pix_map[8][8], 0);
        run(500); pattern_sel = 2'd3; run(FT - 500);
        clear_stats();
        run(3 * FT);
        chk("noise_flips_seen", flips > 0, 1);
        chk("noise_flips_sparse", flips < 40, 1);

        // Drain: the frame completes with one frame_done, then silence.
        run(300); en = 1'b0;
        clear_stats();
        run(FT);
        chk("drain_fd_once", fd_cnt, 1);
        clear_stats();
        run(200);
        chk("idle_quiet", nonzero, 0);
        en = 1'b1;
        clear_stats();
        run(FT + 1);
        chk("restart_origin", first_xy, 0);
        chk("restart_fd", fd_cnt, 1);

        // en returns during drain: generation carries straight on.
        run(200); en = 1'b0; run(100); en = 1'b1;
        clear_stats();
        run(FT - 300);
        chk("resume_fd", fd_cnt, 1);
        clear_stats();
        run(FT);
        chk("resume_clken", clken_cnt, HA * VA);

        // Asynchronous reset mid-frame.
        run(100);
        #2 rst = 1'b1;
        #1 chk("async_reset", {o_vs, o_hs, o_clken, o_imgbit, frame_done, o_x, o_y}, 0);
        model_reset();
        clear_stats();
        run(3);
        chk("reset_no_fd", fd_cnt, 0);
        rst = 1'b0;
        run(FT + 1);

        // Randomized enable and selection changes.
        for (int i = 0; i < 12; i++) begin
            run($urandom_range(50, 2500));
            en = ($urandom_range(0, 3) != 0);
            pattern_sel = 2'($urandom_range(0, 3));
        end
        en = 1'b1;
        run(2 * FT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
